writeback_data_pipe: RTL

//   Parametrised write-back data selector and pipeline for the register-file write port.

---
 rtl/writeback_data_pipe.sv | 99 +++++++++
 1 files changed

// File: rtl/writeback_data_pipe.sv
// Write-back data selector and register-file write pipeline.
// Picks one of N_SRC results, carries it with its destination through STAGES registers, and forwards youngest-first.
module writeback_data_pipe #(
    parameter int DATA_W = 32,
    parameter int N_SRC  = 8,
    parameter int SEL_W  = 3,
    parameter int STAGES = 1,
    parameter int ADDR_W = 5
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [N_SRC*DATA_W-1:0]   src_data,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      in_valid,
    input  logic [ADDR_W-1:0]         in_dest,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      err_clr,
    input  logic [ADDR_W-1:0]         fwd_addr,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [ADDR_W-1:0]         out_dest,
    output logic                      out_we,
    output logic                      fwd_hit,
    output logic [DATA_W-1:0]         fwd_data,
    output logic                      sel_err
);

    localparam logic [SEL_W:0] N_SRC_L = (SEL_W+1)'(N_SRC);

    logic              sel_ok;
    logic              advance;
    logic [DATA_W-1:0] sel_data;

    logic [STAGES-1:0] stg_valid;
    logic [DATA_W-1:0] stg_data [STAGES];
    logic [ADDR_W-1:0] stg_dest [STAGES];

    assign sel_ok  = ({1'b0, sel} < N_SRC_L);
    assign advance = !flush && !stall;

    // An out-of-range select matches no source, so the captured data is 0.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (sel == SEL_W'(k)) sel_data = src_data[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stg_valid <= '0;
            for (int i = 0; i < STAGES; i++) begin
                stg_data[i] <= '0;
                stg_dest[i] <= '0;
            end
        end else if (flush) begin
            stg_valid <= '0;
        end else if (!stall) begin
            for (int i = STAGES - 1; i > 0; i--) begin
                stg_valid[i] <= stg_valid[i-1];
                stg_data[i]  <= stg_data[i-1];
                stg_dest[i]  <= stg_dest[i-1];
            end
            stg_valid[0] <= in_valid && sel_ok;
            stg_data[0]  <= sel_data;
            stg_dest[0]  <= in_dest;
        end
    end

    // A new bad select outranks a simultaneous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sel_err <= 1'b0;
        end else if (advance && in_valid && !sel_ok) begin
            sel_err <= 1'b1;
        end else if (err_clr) begin
            sel_err <= 1'b0;
        end
    end

    assign out_valid = stg_valid[STAGES-1];
    assign out_data  = stg_data[STAGES-1];
    assign out_dest  = stg_dest[STAGES-1];
    assign out_we    = out_valid && (out_dest != '0);

    // Scan oldest to youngest so the youngest hit overwrites.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (stg_valid[i] && (stg_dest[i] == fwd_addr) && (fwd_addr != '0)) begin
                fwd_hit  = 1'b1;
                fwd_data = stg_data[i];
            end
        end
    end

endmodule
